// File: rtl/wb_banked_host_if.sv
// Wishbone classic-cycle bus bundle between a bus master and wb_banked_host.
//   adr    byte address            (master -> slave)
//   dat_w  write data              (master -> slave)
//   sel    byte-lane enables       (master -> slave)
//   cyc    bus cycle valid         (master -> slave)
//   stb    strobe                  (master -> slave)
//   we     1 = write, 0 = read     (master -> slave)
//   dat_r  read data               (slave -> master)
//   ack    one-cycle success pulse (slave -> master)
//   err    one-cycle error pulse   (slave -> master)
interface wb_banked_host_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0]   adr;
    logic [DATA_W-1:0]   dat_w;
    logic [DATA_W-1:0]   dat_r;
    logic [DATA_W/8-1:0] sel;
    logic                cyc;
    logic                stb;
    logic                we;
    logic                ack;
    logic                err;

    modport master (
        output adr, dat_w, sel, cyc, stb, we,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, cyc, stb, we,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_banked_host.sv
// Parametrised Wishbone classic-cycle target serving per-slave register banks.
// The address splits into byte offset (low), word index, and slave index (all
// remaining upper bits). Requests pass through a fixed wait-state delay, may be
// stalled by the target slave's busy line (with timeout), and complete with a
// single-cycle ack or err pulse.
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   wb_master  Wishbone bus (slave modport)
//   slv_busy   per-slave stall request
//   err_count  saturating count of err pulses
module wb_banked_host #(
    parameter int          DATA_W         = 32,
    parameter int          ADDR_W         = 32,
    parameter int          SLAVE_COUNT    = 8,
    parameter int          BANK_DEPTH     = 4,
    parameter int          WAIT_STATES    = 1,
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] INIT_BASE      = 32'h9ABC_DEF0
) (
    input  logic                   clk,
    input  logic                   rst,
    wb_banked_host_if.slave        wb_master,
    input  logic [SLAVE_COUNT-1:0] slv_busy,
    output logic [7:0]             err_count
);
    localparam int NB   = DATA_W / 8;
    localparam int BO   = $clog2(NB);
    localparam int WI   = $clog2(BANK_DEPTH);
    localparam int SFW  = ADDR_W - BO - WI;
    localparam int SW   = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1;
    localparam int NPAD = 2 ** SW;
    localparam int TW   = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   dat_w_q, dat_w_d;
    logic [NB-1:0]       sel_q, sel_d;
    logic                we_q, we_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   dat_r_q, dat_r_d;
    logic [7:0]          err_count_q, err_count_d;
    logic                wr_en;

    // Decode always works on the latched request so master-side changes after
    // the sampling edge cannot disturb an in-flight access.
    logic [SFW-1:0]      slave_field;
    logic [WI-1:0]       word_idx;
    logic [BO-1:0]       byte_off;
    logic [SW-1:0]       slave_sel;
    logic                decode_err;
    logic [NPAD-1:0]     busy_pad;
    logic                target_busy;
    logic [TW-1:0]       tmo_inc;
    logic [DATA_W-1:0]   rd_word [NPAD][BANK_DEPTH];

    assign slave_field = adr_q[ADDR_W-1 -: SFW];
    assign word_idx    = adr_q[BO +: WI];
    assign byte_off    = adr_q[BO-1:0];
    assign slave_sel   = slave_field[SW-1:0];
    // Full-width compare: any set upper bit makes the slave index out of range.
    assign decode_err  = ({1'b0, slave_field} >= (SFW+1)'(SLAVE_COUNT)) || (byte_off != '0);
    // Padding to a power of two keeps the index in range for odd slave counts;
    // padded entries are only reachable when decode_err already wins.
    assign busy_pad    = NPAD'(slv_busy);
    assign target_busy = busy_pad[slave_sel];
    assign tmo_inc     = tmo_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        tmo_d       = tmo_q;
        adr_d       = adr_q;
        dat_w_d     = dat_w_q;
        sel_d       = sel_q;
        we_d        = we_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        dat_r_d     = dat_r_q;
        err_count_d = err_count_q;
        wr_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                wait_cnt_d = '0;
                tmo_d      = '0;
                if (wb_master.cyc && wb_master.stb) begin
                    adr_d   = wb_master.adr;
                    dat_w_d = wb_master.dat_w;
                    sel_d   = wb_master.sel;
                    we_d    = wb_master.we;
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (!wb_master.cyc) begin
                    wait_cnt_d = '0;
                    state_d    = S_IDLE;
                end else if (wait_cnt_q == 4'(WAIT_STATES - 1)) begin
                    wait_cnt_d = '0;
                    state_d    = S_ACCESS;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_ACCESS: begin
                if (!wb_master.cyc) begin
                    tmo_d   = '0;
                    state_d = S_IDLE;
                end else if (decode_err) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (target_busy) begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TW'(TIMEOUT_CYCLES - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    if (we_q) begin
                        wr_en = 1'b1;
                    end else begin
                        dat_r_d = rd_word[slave_sel][word_idx];
                    end
                    ack_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                tmo_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            tmo_q       <= '0;
            adr_q       <= '0;
            dat_w_q     <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            dat_r_q     <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            tmo_q       <= tmo_d;
            adr_q       <= adr_d;
            dat_w_q     <= dat_w_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            dat_r_q     <= dat_r_d;
            err_count_q <= err_count_d;
        end
    end

    // Bank words are individual registers because every word must come out of
    // reset holding its own seed value.
    for (genvar gi = 0; gi < NPAD; gi++) begin : g_slave
        for (genvar gj = 0; gj < BANK_DEPTH; gj++) begin : g_word
            if (gi < SLAVE_COUNT) begin : g_real
                localparam logic [31:0] SEED = INIT_BASE + 32'(gi) * 32'h200 + 32'(gj) * 32'd4;
                logic [DATA_W-1:0] word_q;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        word_q <= DATA_W'(SEED);
                    end else if (wr_en && (slave_sel == SW'(gi)) && (word_idx == WI'(gj))) begin
                        for (int b = 0; b < NB; b++) begin
                            if (sel_q[b]) begin
                                word_q[8*b +: 8] <= dat_w_q[8*b +: 8];
                            end
                        end
                    end
                end
                assign rd_word[gi][gj] = word_q;
            end else begin : g_pad
                assign rd_word[gi][gj] = '0;
            end
        end
    end

    assign wb_master.dat_r = dat_r_q;
    assign wb_master.ack   = ack_q;
    assign wb_master.err   = err_q;
    assign err_count       = err_count_q;
endmodule

// File: tb/tb_wb_banked_host.sv
// Randomised self-checking bench for wb_banked_host (default parameters).
// A behavioural model holds the bank contents as a plain array and predicts
// outcome, latency, read data and error count for each transaction.
module tb_wb_banked_host;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NS = 8;
    localparam int BD = 4;
    localparam int WS = 1;
    localparam int TO = 16;
    localparam int MAX_EDGES = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NS-1:0] slv_busy;
    logic [7:0]    err_count;

    always #5 clk = ~clk;

    wb_banked_host_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    wb_banked_host #(
        .DATA_W(DW), .ADDR_W(AW), .SLAVE_COUNT(NS), .BANK_DEPTH(BD),
        .WAIT_STATES(WS), .TIMEOUT_CYCLES(TO), .INIT_BASE(32'h9ABCDEF0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wb_master(bus),
        .slv_busy(slv_busy),
        .err_count(err_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model
    logic [31:0] m_mem [NS][BD];
    logic [31:0] m_dat_r;
    int          m_errcnt;

    task automatic model_reset();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < BD; w++)
                m_mem[s][w] = 32'h9ABCDEF0 + s * 32'h200 + w * 4;
        m_dat_r  = '0;
        m_errcnt = 0;
    endtask

    // rel: edge (counted from the sampling edge) after which busy is released;
    // 0 means busy stays asserted.
    task automatic run_txn(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                           input logic we, input logic [NS-1:0] busy, input int rel, input string tag);
        int slave, word, off, busy_n, exp_lat, n;
        bit dec_err, exp_err, got;
        slave   = int'(adr >> 4);
        word    = int'((adr >> 2) & 3);
        off     = int'(adr & 3);
        dec_err = (slave >= NS) || (off != 0);
        if (dec_err) begin
            exp_err = 1; exp_lat = WS + 1;
        end else if (busy[slave]) begin
            busy_n = (rel == 0) ? 1000 : rel - WS;
            if (busy_n >= TO - 1) begin
                exp_err = 1; exp_lat = WS + TO - 1;
            end else begin
                exp_err = 0; exp_lat = WS + busy_n + 1;
            end
        end else begin
            exp_err = 0; exp_lat = WS + 1;
        end
        if (exp_err) begin
            if (m_errcnt < 255) m_errcnt++;
        end else if (we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) m_mem[slave][word][8*b +: 8] = dat[8*b +: 8];
        end else begin
            m_dat_r = m_mem[slave][word];
        end

        @(negedge clk);
        bus.adr = adr; bus.dat_w = dat; bus.sel = sel; bus.we = we;
        bus.cyc = 1'b1; bus.stb = 1'b1; slv_busy = busy;
        @(posedge clk);
        #1;
        // Only cyc matters after sampling; scramble the rest.
        bus.stb = 1'b0; bus.adr = $urandom; bus.dat_w = $urandom;
        bus.sel = 4'($urandom); bus.we = 1'($urandom);
        n = 0; got = 0;
        while (n < MAX_EDGES && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.ack || bus.err) got = 1;
            else if (n == rel) slv_busy = '0;
        end
        bus.cyc = 1'b0;
        check({tag, " outcome"}, {30'd0, bus.ack, bus.err}, exp_err ? 32'd1 : 32'd2);
        check({tag, " latency"}, got ? n : 0, exp_lat);
        @(posedge clk);
        #1;
        check({tag, " pulse_end"}, {30'd0, bus.ack, bus.err}, 32'd0);
        check({tag, " dat_r"}, bus.dat_r, m_dat_r);
        check({tag, " err_count"}, {24'd0, err_count}, m_errcnt);
        slv_busy = '0;
        $display("txn %-10s adr=%h we=%0d sel=%b dat=%h -> ack=%0d lat=%0d dat_r=%h err_count=%0d",
                 tag, adr, we, sel, dat, !exp_err, exp_lat, m_dat_r, m_errcnt);
    endtask

    initial begin
        int seen;
        bus.adr = '0; bus.dat_w = '0; bus.sel = '0;
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        slv_busy = '0;
        model_reset();
        #2 rst = 1'b1;
        #1;
        check("rst ack", {31'd0, bus.ack}, 0);
        check("rst err", {31'd0, bus.err}, 0);
        check("rst dat_r", bus.dat_r, 0);
        check("rst err_count", {24'd0, err_count}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Directed scenarios
        run_txn(32'h14, 32'h0, 4'hF, 1'b0, '0, 0, "rd14");
        check("rd14 seed", bus.dat_r, 32'h9ABCE0F4);
        run_txn(32'h28, 32'hDEADBEEF, 4'b0101, 1'b1, '0, 0, "wr28");
        run_txn(32'h28, 32'h0, 4'hF, 1'b0, '0, 0, "rd28");
        run_txn(32'h80, 32'h0, 4'hF, 1'b0, 8'hFF, 0, "rd80");
        run_txn(32'h02, 32'h0, 4'hF, 1'b0, 8'hFF, 0, "rd02");
        check("decode err_count", {24'd0, err_count}, 2);
        run_txn(32'h30, 32'h0, 4'hF, 1'b0, 8'h08, 0, "busy_to");
        run_txn(32'h30, 32'h0, 4'hF, 1'b0, 8'h08, 5, "busy_rel");
        run_txn(32'h30, 32'h0, 4'hF, 1'b0, 8'hF7, 0, "busy_other");

        // Abort one cycle into WAIT: nothing may complete or be written.
        @(negedge clk);
        bus.adr = 32'h0; bus.dat_w = 32'h12345678; bus.sel = 4'hF; bus.we = 1'b1;
        bus.cyc = 1'b1; bus.stb = 1'b1;
        @(posedge clk);
        #1 bus.cyc = 1'b0; bus.stb = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1 if (bus.ack || bus.err) seen++;
        end
        check("abort pulses", seen, 0);
        check("abort err_count", {24'd0, err_count}, m_errcnt);
        $display("txn abort      adr=00000000 we=1 -> no completion");
        run_txn(32'h00, 32'h0, 4'hF, 1'b0, '0, 0, "rd00");

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            int rel;
            a = ($urandom_range(0, 9) << 4) | ($urandom_range(0, 3) << 2);
            if ($urandom_range(0, 7) == 0) a = a | $urandom_range(1, 3);
            rel = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(WS + 1, WS + 20);
            run_txn(a, $urandom, 4'($urandom), 1'($urandom), NS'($urandom), rel, "rand");
        end

        // Saturation
        for (int i = 0; i < 260; i++) run_txn(32'h80, 32'h0, 4'hF, 1'b0, '0, 0, "sat");
        check("sat err_count", {24'd0, err_count}, 255);

        // Reset mid-ACCESS while stalled after a write
        run_txn(32'h34, 32'hCAFEF00D, 4'hF, 1'b1, '0, 0, "wr34");
        @(negedge clk);
        bus.adr = 32'h34; bus.sel = 4'hF; bus.we = 1'b0;
        bus.cyc = 1'b1; bus.stb = 1'b1; slv_busy = 8'h08;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst ack", {31'd0, bus.ack}, 0);
        check("midrst err", {31'd0, bus.err}, 0);
        check("midrst dat_r", bus.dat_r, 0);
        check("midrst err_count", {24'd0, err_count}, 0);
        model_reset();
        bus.cyc = 1'b0; bus.stb = 1'b0; slv_busy = '0;
        @(negedge clk) rst = 1'b0;
        run_txn(32'h34, 32'h0, 4'hF, 1'b0, '0, 0, "rd34_seed");
        run_txn(32'h28, 32'h0, 4'hF, 1'b0, '0, 0, "rd28_seed");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
